// File: rtl/seq_sub_pkg.sv
// Shared types and default sizing for the sequential carry-select subtractor.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

endpackage

// File: rtl/csel_slice.sv
// Combinational carry-select slice: both carry-in sums are formed up front,
// and cin only drives the final mux.
module csel_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] s0;
    logic [SLICE:0] s1;

    assign s0 = {1'b0, x} + {1'b0, y};
    assign s1 = {1'b0, x} + {1'b0, y} + (SLICE+1)'(1);

    assign {cout, s} = cin ? s1 : s0;

endmodule

// File: rtl/seq_csel_subtractor.sv
// Multi-cycle a - b, resolved one carry-select slice per clock behind
// valid/ready input and output ports.
module seq_csel_subtractor
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready and out_valid are decoded from the state register only, so
    // neither depends combinationally on in_valid or out_ready.

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic             carry;

    logic [SLICE-1:0] x_k;
    logic [SLICE-1:0] y_k;
    logic [SLICE-1:0] s_k;
    logic             cout_k;

    assign x_k = a_q[cnt*SLICE +: SLICE];
    assign y_k = nb_q[cnt*SLICE +: SLICE];

    csel_slice #(.SLICE(SLICE)) u_slice (
        .x    (x_k),
        .y    (y_k),
        .cin  (carry),
        .s    (s_k),
        .cout (cout_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction as a + ~b + 1: the inverted subtrahend is latched and the
    // carry chain starts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            nb_q  <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        nb_q  <= ~b;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    diff[cnt*SLICE +: SLICE] <= s_k;
                    carry                    <= cout_k;
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        // Final slice: flags come straight from this slice's result.
                        bout <= ~cout_k;
                        ovf  <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) &&
                                (s_k[SLICE-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
